// File: rtl/ucdp_sync_tx_if.sv
// ucdp_sync_tx_if: handshake bundle for the source side of a toggle CDC link.
//   valid_i/ready_o/data_i : local word handshake into the sender
//   data_o/req_o           : word and request toggle toward the destination
//   ack_i                  : acknowledge toggle from the destination (async)
//   busy_o/done_o          : transfer status
//   timeout_o              : sticky ack-timeout flag
// slave modport is the sender's view; master is the environment's view.
interface ucdp_sync_tx_if #(
    parameter int unsigned width_p = 8
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic [width_p-1:0] data_o;
    logic               req_o;
    logic               ack_i;
    logic               busy_o;
    logic               done_o;
    logic               timeout_o;

    modport slave (
        input  valid_i, data_i, ack_i,
        output ready_o, data_o, req_o, busy_o, done_o, timeout_o
    );

    modport master (
        output valid_i, data_i, ack_i,
        input  ready_o, data_o, req_o, busy_o, done_o, timeout_o
    );
endinterface

// File: rtl/ucdp_sync_tx.sv
// ucdp_sync_tx: source side of a two-phase request/acknowledge CDC handshake.
// A word accepted on valid_i/ready_o is held on data_o; one cycle later req_o
// toggles, and the block waits until the synchronized ack matches req_o.
// Ports:
//   main_clk_i    : clock
//   main_rst_an_i : synchronous active-low reset
//   bus           : ucdp_sync_tx_if.slave (handshake, data, req/ack, status)
// Optional feature: define UCDP_SYNC_TX_TIMEOUT_EN to enable the WAIT-cycle
// counter driving timeout_o; otherwise timeout_o is tied to 0.
module ucdp_sync_tx #(
    parameter int unsigned        width_p   = 8,
    parameter int unsigned        stages_p  = 2,
    parameter logic [width_p-1:0] rstval_p  = '0,
    parameter int unsigned        timeout_p = 255
) (
    input logic           main_clk_i,
    input logic           main_rst_an_i,
    ucdp_sync_tx_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    state_e              state_q;
    logic                req_q;
    logic                done_q;
    logic                busy_q;
    logic [width_p-1:0]  data_q;
    logic [stages_p-1:0] ack_sync_q;
    logic                ack_s;
    logic                ready;

    // Plain flop chain: ack_i goes straight into the first flop.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[stages_p-2:0], bus.ack_i};
        end
    end

    assign ack_s = ack_sync_q[stages_p-1];

    // A mismatched ack in IDLE (spurious toggle) blocks new words until it realigns.
    assign ready = (state_q == StIdle) && (ack_s == req_q) && main_rst_an_i;

    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= rstval_p;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.valid_i && ready) begin
                        data_q  <= bus.data_i;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                // Give data_o a full cycle to settle before the request toggles.
                StLoad: begin
                    req_q   <= ~req_q;
                    state_q <= StWait;
                end
                StWait: begin
                    if (ack_s == req_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef UCDP_SYNC_TX_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(timeout_p - 1);

    logic [15:0] wait_cnt_q;
    logic        timeout_q;

    // Counter is cleared on the LOAD->WAIT edge; flag sets when it reaches timeout_p.
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (state_q == StLoad) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait) begin
            if (wait_cnt_q != 16'hffff) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            if (wait_cnt_q == TimeoutLast) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(timeout_p);
    assign bus.timeout_o      = 1'b0;
`endif

    assign bus.ready_o = ready;
    assign bus.data_o  = data_q;
    assign bus.req_o   = req_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ucdp_sync_tx.sv
// Self-checking bench for ucdp_sync_tx (width 8, 2 sync stages, timeout 16).
// Destination model: ack_i follows req_o delayed by 3 cycles, or is forced.
module tb_ucdp_sync_tx;

`ifdef UCDP_SYNC_TX_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic ack_auto;
    logic ack_force;
    logic [2:0] req_d;
    int errors;
    int checks;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    ucdp_sync_tx_if #(.width_p(8)) bus ();

    ucdp_sync_tx #(
        .width_p  (8),
        .stages_p (2),
        .rstval_p (8'h00),
        .timeout_p(16)
    ) dut (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Destination receiver: resets together with the sender.
    always @(posedge clk) begin
        if (!rst_n) req_d <= 3'b000;
        else        req_d <= {req_d[1:0], bus.req_o};
    end

    assign bus.ack_i = ack_auto ? req_d[2] : ack_force;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i = 8'hff;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks += 4;
            if (bus.req_o !== 1'b0) begin
                errors++; $display("FAIL reset_req: got %b want 0", bus.req_o);
            end
            if (bus.data_o !== 8'h00) begin
                errors++; $display("FAIL reset_data: got %h want 00", bus.data_o);
            end
            if (bus.ready_o !== 1'b0) begin
                errors++; $display("FAIL reset_ready: got %b want 0", bus.ready_o);
            end
            if (bus.busy_o !== 1'b0) begin
                errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o);
            end
        end
        rst_n = 1'b1;
        bus.valid_i = 1'b0;
        #1;
        checks += 3;
        if (bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", bus.ready_o);
        end
        if (bus.done_o !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", bus.done_o);
        end
        if (bus.timeout_o !== 1'b0) begin
            errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_o);
        end
    endtask

    // Single transfer of A5, then 3C held during WAIT and accepted in the done cycle.
    task automatic test_single_and_back_to_back();
        bit seen;
        logic [7:0] exp_data;
        bus.valid_i = 1'b1;
        bus.data_i = 8'ha5;
        exp_q.push_back(8'ha5);
        tick();
        checks += 3;
        if (bus.data_o !== 8'ha5) begin
            errors++; $display("FAIL capture_data: got %h want a5", bus.data_o);
        end
        if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            errors++; $display("FAIL load_status: got busy=%b ready=%b want 1 0",
                               bus.busy_o, bus.ready_o);
        end
        if (bus.req_o !== 1'b0) begin
            errors++; $display("FAIL load_req: got %b want 0", bus.req_o);
        end
        bus.data_i = 8'h3c;
        for (int n = 1; n <= 9; n++) begin
            tick();
            exp_data = (n < 8) ? 8'ha5 : 8'h3c;
            checks += 5;
            if (bus.req_o !== ((n >= 1 && n < 9) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL xfer_req[%0d]: got %b", n, bus.req_o);
            end
            if (bus.ack_i !== ((n >= 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL xfer_ack[%0d]: got %b", n, bus.ack_i);
            end
            if (bus.done_o !== ((n == 7) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL xfer_done[%0d]: got %b", n, bus.done_o);
            end
            if (bus.ready_o !== ((n == 7) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL xfer_ready[%0d]: got %b", n, bus.ready_o);
            end
            if (bus.data_o !== exp_data) begin
                errors++; $display("FAIL xfer_data[%0d]: got %h want %h", n, bus.data_o, exp_data);
            end
            if (bus.done_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_empty: got done want queued word");
                end else begin
                    exp_word = exp_q.pop_front();
                    if (bus.data_o !== exp_word) begin
                        errors++; $display("FAIL sb_word: got %h want %h", bus.data_o, exp_word);
                    end
                end
            end
            if (n == 7 && bus.ready_o === 1'b1 && bus.valid_i === 1'b1) exp_q.push_back(8'h3c);
            if (n == 8) bus.valid_i = 1'b0;
        end
        wait_done(20, seen);
        checks += 2;
        if (!seen) begin
            errors++; $display("FAIL b2b_done: got no done want done pulse");
        end
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_empty2: got done want queued word");
        end else begin
            exp_word = exp_q.pop_front();
            if (bus.data_o !== exp_word) begin
                errors++; $display("FAIL sb_word2: got %h want %h", bus.data_o, exp_word);
            end
        end
        tick();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got ready=%b done=%b want 1 0",
                               bus.ready_o, bus.done_o);
        end
    endtask

    task automatic test_spurious_ack();
        ack_force = 1'b0;
        ack_auto = 1'b0;
        tick();
        ack_force = 1'b1;
        tick();
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL spur_ready1: got %b want 1", bus.ready_o);
        end
        tick();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++; $display("FAIL spur_ready2: got %b want 0", bus.ready_o);
        end
        ack_force = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i = 8'h77;
        tick();
        checks += 2;
        if (bus.ready_o !== 1'b0) begin
            errors++; $display("FAIL spur_ready3: got %b want 0", bus.ready_o);
        end
        if (bus.data_o !== 8'h3c || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL spur_ignore: got data=%h busy=%b want 3c 0",
                               bus.data_o, bus.busy_o);
        end
        bus.valid_i = 1'b0;
        tick();
        checks += 2;
        if (bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL spur_ready4: got %b want 1", bus.ready_o);
        end
        if (bus.req_o !== 1'b0 || bus.data_o !== 8'h3c) begin
            errors++; $display("FAIL spur_hold: got req=%b data=%h want 0 3c",
                               bus.req_o, bus.data_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        int dones;
        ack_auto = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i = 8'h5a;
        exp_q.push_back(8'h5a);
        tick();
        bus.valid_i = 1'b0;
        tick();
        checks++;
        if (bus.req_o !== 1'b1) begin
            errors++; $display("FAIL mid_req: got %b want 1", bus.req_o);
        end
        tick();
        rst_n = 1'b0;
        tick();
        checks += 2;
        if (bus.req_o !== 1'b0 || bus.data_o !== 8'h00) begin
            errors++; $display("FAIL mid_rst_vals: got req=%b data=%h want 0 00",
                               bus.req_o, bus.data_o);
        end
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst_stat: got busy=%b done=%b want 0 0",
                               bus.busy_o, bus.done_o);
        end
        rst_n = 1'b1;
        exp_q.delete();
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.done_o !== 1'b0) dones++;
        end
        checks += 2;
        if (dones != 0) begin
            errors++; $display("FAIL mid_no_done: got %0d pulses want 0", dones);
        end
        if (bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL mid_ready: got %b want 1", bus.ready_o);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        logic exp_to;
        ack_force = 1'b0;
        ack_auto = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i = 8'h99;
        exp_q.push_back(8'h99);
        tick();
        bus.valid_i = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_to = TimeoutEn && (n >= 17);
            checks++;
            if (bus.timeout_o !== exp_to) begin
                errors++; $display("FAIL timeout[%0d]: got %b want %b", n, bus.timeout_o, exp_to);
            end
        end
        ack_force = 1'b1;
        wait_done(10, seen);
        checks += 3;
        if (!seen) begin
            errors++; $display("FAIL timeout_done: got no done want done pulse");
        end
        if (bus.timeout_o !== TimeoutEn) begin
            errors++; $display("FAIL timeout_sticky: got %b want %b", bus.timeout_o, TimeoutEn);
        end
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_empty3: got done want queued word");
        end else begin
            exp_word = exp_q.pop_front();
            if (bus.data_o !== exp_word) begin
                errors++; $display("FAIL sb_word3: got %h want %h", bus.data_o, exp_word);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ack_auto = 1'b1;
        ack_force = 1'b0;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i = 8'h00;
        test_reset();
        test_single_and_back_to_back();
        test_spurious_ack();
        test_reset_mid_wait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
